// File: rtl/axi_burst_writer.sv
// Purpose : AXI4 write master; drains req_len beats from a show-ahead FIFO as INCR bursts and keeps a frame address pointer.
// Latency : resp 1 cycle after a request is seen in IDLE; AW issued 1 cycle after resp; done 1 cycle after the FIN state.
// Backpressure: AW held until awready; W stalls on fifo_empty or !wready (no skip/pad); one burst outstanding at a time.
//
// Ports:
//   clock, rst_n                 - clock, asynchronous active-low reset
//   base_addr, frame_start       - frame base byte address and pointer reload pulse
//   burst_req, tail_req, req_len - level requests (held until resp) and beat count
//   resp, done                   - one-cycle acceptance / completion pulses
//   fifo_data, fifo_empty, fifo_rd_en - show-ahead line FIFO head, empty flag, pop
//   aw*, w*, b*                  - AXI4 write address / data / response channels
//   wr_err                       - sticky error flag, set on any non-OKAY bresp
//
// Optional feature: define BOUNDARY_4K_SPLIT_EN to also cut bursts at 4 KB address boundaries.

module axi_burst_writer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LSIZE      = 9,
    parameter int MAX_BURST  = 256
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic                    frame_start,
    input  logic                    burst_req,
    input  logic                    tail_req,
    input  logic [LSIZE-1:0]        req_len,
    output logic                    resp,
    output logic                    done,
    input  logic [DATA_WIDTH-1:0]   fifo_data,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    wr_err
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);

    typedef enum logic [2:0] {
        IDLE, ACK, ADDR, DATA, BWAIT, NEXT, FIN
    } state_t;

    state_t                  state_q;
    logic [LSIZE-1:0]        rem_q;
    logic [LSIZE-1:0]        chunk_q;
    logic [LSIZE-1:0]        beat_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic                    fs_pend_q;
    logic                    resp_q;
    logic                    done_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [7:0]              awlen_q;
    logic                    awvalid_q;
    logic                    bready_q;
    logic                    wr_err_q;

    logic [LSIZE-1:0]        rem_d;
    logic [ADDR_WIDTH-1:0]   ptr_d;
    logic [LSIZE-1:0]        chunk_d;
    logic [LSIZE-1:0]        src_rem;
    logic [31:0]             lim;
`ifdef BOUNDARY_4K_SPLIT_EN
    logic [11:0]             ptr_lo;
    logic [31:0]             room;
`endif

    // Values the NEXT state commits; also used to size the following burst.
    assign rem_d = rem_q - chunk_q;
    assign ptr_d = ptr_q + (ADDR_WIDTH'(chunk_q) << BSHIFT);

    // The burst size is computed on the transition into ADDR (from ACK with the
    // fresh req_len, from NEXT with the updated remaining/pointer), so AW
    // outputs are registered and stable for the whole ADDR state.
    always_comb begin
        src_rem = (state_q == ACK) ? req_len : rem_d;
        lim     = 32'(src_rem);
        if (lim > MAX_BURST) lim = MAX_BURST;
`ifdef BOUNDARY_4K_SPLIT_EN
        ptr_lo = (state_q == ACK) ? ptr_q[11:0] : ptr_d[11:0];
        room   = (32'd4096 - 32'(ptr_lo)) >> BSHIFT;
        if (lim > room) lim = room;
`endif
        chunk_d = lim[LSIZE-1:0];
    end

    // W channel follows the FIFO head directly (show-ahead), so it is
    // combinational from state and fifo_empty.
    assign wvalid     = (state_q == DATA) && !fifo_empty;
    assign fifo_rd_en = wvalid && wready;
    assign wdata      = wvalid ? fifo_data : '0;
    assign wstrb      = {BYTES{wvalid}};
    assign wlast      = wvalid && (beat_q == chunk_q - 1'b1);

    assign awsize  = 3'(BSHIFT);
    assign awburst = 2'b01;
    assign awaddr  = awaddr_q;
    assign awlen   = awlen_q;
    assign awvalid = awvalid_q;
    assign bready  = bready_q;
    assign resp    = resp_q;
    assign done    = done_q;
    assign wr_err  = wr_err_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            chunk_q   <= '0;
            beat_q    <= '0;
            ptr_q     <= '0;
            fs_pend_q <= 1'b0;
            resp_q    <= 1'b0;
            done_q    <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            done_q <= 1'b0;
            // A frame_start outside IDLE is remembered and applied when FIN
            // hands back to IDLE (FIN clears it below).
            if (frame_start && state_q != IDLE) fs_pend_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (frame_start) ptr_q <= base_addr;
                    // Tail and burst requests share one path, so no arbitration is needed.
                    if (burst_req || tail_req) begin
                        state_q <= ACK;
                        resp_q  <= 1'b1;
                    end
                end
                ACK: begin
                    rem_q <= req_len;
                    if (req_len == '0) begin
                        state_q <= FIN;
                    end else begin
                        state_q   <= ADDR;
                        chunk_q   <= chunk_d;
                        awaddr_q  <= ptr_q;
                        awlen_q   <= 8'(chunk_d - 1'b1);
                        awvalid_q <= 1'b1;
                    end
                end
                ADDR: begin
                    if (awready) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (fifo_rd_en) begin
                        beat_q <= beat_q + 1'b1;
                        if (wlast) begin
                            state_q  <= BWAIT;
                            bready_q <= 1'b1;
                        end
                    end
                end
                BWAIT: begin
                    if (bvalid) begin
                        bready_q <= 1'b0;
                        if (bresp != 2'b00) wr_err_q <= 1'b1;
                        state_q  <= NEXT;
                    end
                end
                NEXT: begin
                    rem_q <= rem_d;
                    ptr_q <= ptr_d;
                    if (rem_d != '0) begin
                        state_q   <= ADDR;
                        chunk_q   <= chunk_d;
                        awaddr_q  <= ptr_d;
                        awlen_q   <= 8'(chunk_d - 1'b1);
                        awvalid_q <= 1'b1;
                    end else begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                    fs_pend_q <= 1'b0;
                    if (frame_start || fs_pend_q) ptr_q <= base_addr;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_writer.sv
// Purpose : self-checking bench for axi_burst_writer (vector table, corner sequences, random traffic).
// Latency : checks resp/done pulse counts and the zero-length resp-to-done gap.
// Backpressure: bench slave and FIFO model insert random awready/wready/bvalid/fifo_empty stalls.

module tb_axi_burst_writer;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LS = 9;
    localparam int MB = 256;
    localparam int BY = DW / 8;

    logic            clock = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   base_addr;
    logic            frame_start, burst_req, tail_req;
    logic [LS-1:0]   req_len;
    logic            resp, done;
    logic [DW-1:0]   fifo_data;
    logic            fifo_empty, fifo_rd_en;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid, awready;
    logic [DW-1:0]   wdata;
    logic [BY-1:0]   wstrb;
    logic            wlast, wvalid, wready;
    logic [1:0]      bresp;
    logic            bvalid, bready, wr_err;

    axi_burst_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSIZE(LS), .MAX_BURST(MB)) dut (
        .clock(clock), .rst_n(rst_n), .base_addr(base_addr), .frame_start(frame_start),
        .burst_req(burst_req), .tail_req(tail_req), .req_len(req_len), .resp(resp), .done(done),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready), .wr_err(wr_err)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_data[$];
    logic [AW-1:0] aw_addr_log[$];
    logic [7:0]    aw_len_log[$];
    logic [AW-1:0] exp_a[$];
    logic [7:0]    exp_l[$];
    int  resp_cnt, done_cnt, resp_cyc, done_cyc, cyc;
    int  wbeats, widx, wbeat, b_owed, b_num;
    int  err_at = -1;
    bit  pop_flag, b_hs, rnd_en, mon_en;
    logic [AW-1:0] m_ptr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model and AXI slave: inputs change 1 time unit after the rising edge.
    always begin
        logic [DW-1:0] tmp;
        @(posedge clock);
        #1;
        if (pop_flag) begin
            if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
            pop_flag = 1'b0;
        end
        fifo_empty = (fifo_q.size() == 0) || (rnd_en && $urandom_range(0, 3) == 0);
        fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        awready    = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        wready     = rnd_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (b_hs) begin
            bvalid = 1'b0;
            bresp  = 2'b00;
            b_hs   = 1'b0;
        end else if (!bvalid && b_owed > 0 && (!rnd_en || $urandom_range(0, 1) == 1)) begin
            bvalid = 1'b1;
            bresp  = (b_num == err_at) ? 2'b10 : 2'b00;
            b_num++;
            b_owed--;
        end
    end

    // Monitor: outputs sampled on the falling edge; handshakes seen here complete on the next rising edge.
    always @(negedge clock) begin
        if (mon_en) begin
            cyc++;
            if (resp) begin resp_cnt++; resp_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            chk("rd_en_is_handshake", fifo_rd_en, wvalid && wready);
            if (wvalid) chk("wvalid_while_empty", fifo_empty, 0);
            if (fifo_rd_en) pop_flag = 1'b1;
            if (awvalid && awready) begin
                aw_addr_log.push_back(awaddr);
                aw_len_log.push_back(awlen);
            end
            if (wvalid && wready) begin
                chk("w_beat_expected", exp_data.size() > 0, 1);
                if (exp_data.size() > 0) chk("wdata", wdata, exp_data.pop_front());
                chk("wstrb", wstrb, {BY{1'b1}});
                chk("w_after_aw", widx < aw_len_log.size(), 1);
                if (widx < aw_len_log.size()) chk("wlast", wlast, wbeat == int'(aw_len_log[widx]));
                wbeats++;
                if (wlast) begin
                    widx++;
                    wbeat = 0;
                    b_owed++;
                end else begin
                    wbeat++;
                end
            end
            if (bvalid && bready) b_hs = 1'b1;
        end
    end

    // Higher-level reference: split a transfer into bursts by plain arithmetic.
    task automatic model_bursts(input logic [AW-1:0] ptr, input int len);
        int rem;
        int c;
        logic [AW-1:0] p;
        exp_a.delete();
        exp_l.delete();
        rem = len;
        p   = ptr;
        while (rem > 0) begin
            c = (rem < MB) ? rem : MB;
`ifdef BOUNDARY_4K_SPLIT_EN
            if (c > (4096 - int'(p[11:0])) / BY) c = (4096 - int'(p[11:0])) / BY;
`endif
            exp_a.push_back(p);
            exp_l.push_back(8'(c - 1));
            p   = p + AW'(c * BY);
            rem = rem - c;
        end
    endtask

    task automatic pulse_fs(input logic [AW-1:0] b);
        base_addr   = b;
        frame_start = 1'b1;
        @(posedge clock);
        #1;
        frame_start = 1'b0;
    endtask

    // Called and returns at rising edge + 1.
    task automatic run_req(input bit tail, input int len);
        int t;
        aw_addr_log.delete();
        aw_len_log.delete();
        resp_cnt = 0; done_cnt = 0; wbeats = 0; widx = 0; wbeat = 0;
        for (int i = 0; i < len; i++) begin
            logic [DW-1:0] w;
            w = {$urandom, $urandom};
            fifo_q.push_back(w);
            exp_data.push_back(w);
        end
        req_len = LS'(len);
        if (tail) tail_req = 1'b1; else burst_req = 1'b1;
        t = 0;
        while (resp_cnt == 0 && t < 50) begin @(negedge clock); t++; end
        chk("resp_seen", resp_cnt > 0, 1);
        // Upstream keeps the request one cycle past resp.
        @(posedge clock);
        #1;
        burst_req = 1'b0;
        tail_req  = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 20000) begin @(negedge clock); t++; end
        chk("done_seen", done_cnt > 0, 1);
        repeat (3) @(negedge clock);
        chk("resp_count", resp_cnt, 1);
        chk("done_count", done_cnt, 1);
        chk("beat_count", wbeats, len);
        chk("data_left", exp_data.size(), 0);
        chk("fifo_drained", fifo_q.size(), 0);
        if (len == 0) begin
            chk("zero_len_done_gap", done_cyc - resp_cyc, 2);
            chk("zero_len_no_aw", aw_addr_log.size(), 0);
        end
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        bit            fs;
        logic [AW-1:0] base;
        bit            tail;
        int            len;
        int            exp_n;
        logic [AW-1:0] exp_a0;
        int            exp_l0;
        logic [AW-1:0] exp_an;
        int            exp_ln;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    initial begin
        vecs[0] = '{1'b1, 32'h1000_0000, 1'b0, 200, 1, 32'h1000_0000, 199, 32'h1000_0000, 199};
        vecs[1] = '{1'b1, 32'h1000_0000, 1'b0, 300, 2, 32'h1000_0000, 255, 32'h1000_0800, 43};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 5,   1, 32'h1000_0960, 4,   32'h1000_0960, 4};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 0,   0, 32'h0,         0,   32'h0,         0};
        vecs[4] = '{1'b0, 32'h0,         1'b1, 1,   1, 32'h1000_0988, 0,   32'h1000_0988, 0};
`ifdef BOUNDARY_4K_SPLIT_EN
        vecs[5] = '{1'b1, 32'h1000_0F80, 1'b0, 64,  2, 32'h1000_0F80, 15,  32'h1000_1000, 47};
`else
        vecs[5] = '{1'b1, 32'h1000_0F80, 1'b0, 64,  1, 32'h1000_0F80, 63,  32'h1000_0F80, 63};
`endif
        vecs[6] = '{1'b1, 32'h4000_0000, 1'b0, 256, 1, 32'h4000_0000, 255, 32'h4000_0000, 255};
        vecs[7] = '{1'b0, 32'h0,         1'b0, 257, 2, 32'h4000_0800, 255, 32'h4000_1000, 0};

        rst_n = 1'b0; base_addr = '0; frame_start = 1'b0; burst_req = 1'b0; tail_req = 1'b0;
        req_len = '0; fifo_data = '0; fifo_empty = 1'b1; awready = 1'b0; wready = 1'b0;
        bresp = 2'b00; bvalid = 1'b0; mon_en = 1'b0; rnd_en = 1'b0; m_ptr = '0;
        b_owed = 0; b_num = 0; cyc = 0; pop_flag = 1'b0; b_hs = 1'b0;

        repeat (2) @(negedge clock);
        chk("rst_ctrl", {resp, done, fifo_rd_en, awvalid, wvalid, wlast, bready, wr_err}, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_awlen", awlen, 0);
        chk("rst_awsize", awsize, 3);
        chk("rst_awburst", awburst, 1);
        chk("rst_wdata", wdata, 0);
        chk("rst_wstrb", wstrb, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].fs) begin
                pulse_fs(vecs[i].base);
                m_ptr = vecs[i].base;
            end
            run_req(vecs[i].tail, vecs[i].len);
            chk($sformatf("v%0d_bursts", i), aw_addr_log.size(), vecs[i].exp_n);
            if (vecs[i].exp_n > 0 && aw_addr_log.size() > 0) begin
                chk($sformatf("v%0d_addr0", i), aw_addr_log[0], vecs[i].exp_a0);
                chk($sformatf("v%0d_len0", i), aw_len_log[0], vecs[i].exp_l0);
                chk($sformatf("v%0d_addrN", i), aw_addr_log[aw_addr_log.size()-1], vecs[i].exp_an);
                chk($sformatf("v%0d_lenN", i), aw_len_log[aw_len_log.size()-1], vecs[i].exp_ln);
            end
            m_ptr = m_ptr + AW'(vecs[i].len * BY);
        end

        // frame_start while a transfer is in flight takes effect for the next request.
        fork
            run_req(1'b0, 100);
            begin
                repeat (40) @(posedge clock);
                #1;
                base_addr   = 32'h3000_0000;
                frame_start = 1'b1;
                @(posedge clock);
                #1;
                frame_start = 1'b0;
            end
        join
        if (aw_addr_log.size() > 0) chk("fs_mid_cur_addr", aw_addr_log[0], m_ptr);
        m_ptr = 32'h3000_0000;
        run_req(1'b0, 8);
        chk("fs_mid_bursts", aw_addr_log.size(), 1);
        if (aw_addr_log.size() > 0) chk("fs_mid_next_addr", aw_addr_log[0], 32'h3000_0000);
        m_ptr = m_ptr + AW'(8 * BY);

        rnd_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int  len;
            bit  tl;
            if ($urandom_range(0, 2) == 0) begin
                logic [AW-1:0] b;
                b = $urandom & 32'hFFFF_FFF8;
                pulse_fs(b);
                m_ptr = b;
            end
            len = (k == 0) ? 511 : int'($urandom_range(0, 400));
            tl  = 1'($urandom_range(0, 1));
            model_bursts(m_ptr, len);
            run_req(tl, len);
            chk($sformatf("r%0d_bursts", k), aw_addr_log.size(), exp_a.size());
            for (int j = 0; j < exp_a.size(); j++) begin
                if (j < aw_addr_log.size()) begin
                    chk($sformatf("r%0d_addr%0d", k, j), aw_addr_log[j], exp_a[j]);
                    chk($sformatf("r%0d_len%0d", k, j), aw_len_log[j], exp_l[j]);
                end
            end
            m_ptr = m_ptr + AW'(len * BY);
        end

        // SLVERR on the second burst; the flag must survive a later clean transfer.
        chk("wr_err_before", wr_err, 0);
        pulse_fs(32'h2000_0000);
        err_at = b_num + 1;
        run_req(1'b0, 300);
        chk("err_bursts", aw_addr_log.size(), 2);
        chk("wr_err_set", wr_err, 1);
        err_at = -1;
        run_req(1'b1, 20);
        chk("wr_err_sticky", wr_err, 1);

        // Asynchronous reset in the middle of a burst.
        rnd_en = 1'b0;
        mon_en = 1'b0;
        for (int i = 0; i < 50; i++) fifo_q.push_back(DW'(i));
        req_len   = LS'(50);
        burst_req = 1'b1;
        begin
            int t;
            t = 0;
            while (!wvalid && t < 200) begin @(negedge clock); t++; end
        end
        chk("rst_mid_reached_data", wvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {resp, done, fifo_rd_en, awvalid, wvalid, wlast, bready, wr_err}, 0);
        chk("rst_mid_awaddr", awaddr, 0);
        burst_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axi_burst_writer.md
Name: axi_burst_writer

Overview:
- AXI4 write master directly downstream of the FIFO status controller.
- Accepts a burst or tail request with a beat count and acknowledges it with `resp`.
- Drains that many beats from the show-ahead line FIFO onto AXI4 AW/W/B, splitting into legal bursts.
- Pulses `done` once the last write response returns. Keeps a running frame address pointer.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI/FIFO data width; power of two, 8..1024.
- LSIZE, 9, width of req_len.
- MAX_BURST, 256, maximum beats per AXI burst (1..256).

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- base_addr  in  ADDR_WIDTH  frame base byte address, aligned to DATA_WIDTH/8
- frame_start  in  1  pulse; reload address pointer from base_addr
- burst_req  in  1  level; full-burst request, held until resp
- tail_req  in  1  level; tail request, held until resp
- req_len  in  LSIZE  beats requested, valid with burst_req/tail_req
- resp  out  1  one-cycle acceptance pulse
- done  out  1  one-cycle completion pulse
- fifo_data  in  DATA_WIDTH  show-ahead FIFO head word
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  pop head word
- awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awvalid  out  AXI AW channel
- awready  in  1
- wdata[DATA_WIDTH], wstrb[DATA_WIDTH/8], wlast, wvalid  out  AXI W channel
- wready  in  1
- bresp[1:0], bvalid  in  AXI B channel
- bready  out  1
- wr_err  out  1  sticky; set on any bresp != OKAY, cleared only by reset

Behaviour:
- Reset: all outputs 0 except awsize = log2(DATA_WIDTH/8) and awburst = 2'b01 (INCR), both constant. Address pointer = 0; FSM = IDLE.
- FSM states: IDLE, ACK, ADDR, DATA, BWAIT, NEXT, FIN.
- IDLE -> ACK when burst_req | tail_req. If both are high, tail has priority; both take the same path.
- ACK: resp = 1 for exactly this cycle. req_len is latched into remaining[LSIZE-1:0].
  - remaining == 0 -> FIN.
  - Otherwise -> ADDR.
- Requests are ignored in every state except IDLE. Upstream holds its request for one cycle after resp, and this must not start a second transfer.
- ADDR:
  - chunk = min(remaining, MAX_BURST).
  - awaddr = pointer, awlen = chunk-1, awvalid = 1 until awready. Registered outputs, stable while awvalid is high.
  - On handshake -> DATA.
- DATA:
  - wvalid = !fifo_empty; wdata = fifo_data; wstrb = all ones.
  - fifo_rd_en = wvalid & wready.
  - wlast = 1 on the chunk-th beat.
  - W starts only after the AW handshake; one burst outstanding at a time.
  - After the last beat handshake -> BWAIT.
- BWAIT: bready = 1. On bvalid, sample bresp; non-OKAY sets wr_err. Then -> NEXT.
- NEXT:
  - remaining -= chunk.
  - pointer += chunk * DATA_WIDTH/8, modulo 2^ADDR_WIDTH.
  - remaining != 0 -> ADDR; else -> FIN.
- FIN: done = 1 for one cycle -> IDLE.
- frame_start:
  - In IDLE: pointer <= base_addr next cycle.
  - In any other state: latched pending and applied on entry to IDLE, before accepting the next request.
- A FIFO underflow (empty mid-burst) only stalls wvalid. Beats are never skipped or padded.
- Asynchronous reset mid-burst drops all state immediately. No AXI cleanup is required; the system resets the slave together with this block.

Optional Feature:
- Macro: BOUNDARY_4K_SPLIT_EN.
- Defined: in ADDR, chunk = min(remaining, MAX_BURST, (4096 - pointer[11:0]) / (DATA_WIDTH/8)), so no burst crosses a 4 KB boundary.
- Undefined: chunk = min(remaining, MAX_BURST). Software must place base_addr and line sizes so bursts never cross 4 KB.

Test Plan:
- Full burst, base 0x1000_0000, frame_start, then burst_req with len 200:
  - resp pulse; AW addr 0x1000_0000, awlen 199; 200 W beats with wlast on beat 200; bvalid OKAY then done pulse.
  - A following request starts at 0x1000_0640.
- Split burst, len 300, MAX_BURST 256:
  - Two bursts: awlen 255 @0x1000_0000, then awlen 43 @0x1000_0800.
  - Exactly one resp pulse and one done pulse.
- Tail and zero length:
  - tail_req len 5 -> awlen 4, 5 beats.
  - tail_req len 0 -> resp, then done 2 cycles later; no AXI traffic; pointer unchanged.
- Backpressure:
  - Random fifo_empty gaps and wready low -> every beat popped exactly once, in order; fifo_rd_en only on handshake.
  - Data matches the FIFO sequence.
- Error and frame behaviour:
  - bresp=SLVERR on the 2nd burst -> wr_err stays 1 through later OKAY bursts.
  - frame_start mid-burst -> next request uses base_addr.
- 4K split (macro defined): pointer 0x1000_0F80, len 64 -> awlen 15 @0x1000_0F80, then awlen 47 @0x1000_1000.
  - Macro undefined -> a single burst with awlen 63.
